// File: rtl/bcd_time_pkg.sv
// Shared types, digit limits and helpers for the BCD time-of-day counter.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Packed HH:MM:SS, most significant digit first (matches the 24-bit port layout).
  typedef struct packed {
    bcd_digit_t h_hi;
    bcd_digit_t h_lo;
    bcd_digit_t m_hi;
    bcd_digit_t m_lo;
    bcd_digit_t s_hi;
    bcd_digit_t s_lo;
  } bcd_time_t;

  // Display word: converted time plus the PM flag.
  typedef struct packed {
    logic      pm;
    bcd_time_t t;
  } disp_t;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam bcd_digit_t DIGIT_MAX_LO      = 4'd9;  // any units digit
  localparam bcd_digit_t DIGIT_MAX_TENS    = 4'd5;  // minute/second tens
  localparam bcd_digit_t DIGIT_MAX_H_HI    = 4'd2;  // hour tens
  localparam bcd_digit_t DIGIT_MAX_H_LO_20 = 4'd3;  // hour units once hour tens is 2

  localparam logic [23:0] TIME_12H_MIDNIGHT = 24'h120000;

  // True when t is a legal 24h time: every digit decimal, hour <= 23, tens of M/S <= 5.
  function automatic logic is_valid_time(input bcd_time_t t);
    logic digits_ok;
    logic hour_ok;
    digits_ok = (t.h_hi <= DIGIT_MAX_LO) && (t.h_lo <= DIGIT_MAX_LO) &&
                (t.m_hi <= DIGIT_MAX_LO) && (t.m_lo <= DIGIT_MAX_LO) &&
                (t.s_hi <= DIGIT_MAX_LO) && (t.s_lo <= DIGIT_MAX_LO);
    hour_ok   = (t.h_hi < DIGIT_MAX_H_HI) ||
                ((t.h_hi == DIGIT_MAX_H_HI) && (t.h_lo <= DIGIT_MAX_H_LO_20));
    return digits_ok && hour_ok && (t.m_hi <= DIGIT_MAX_TENS) && (t.s_hi <= DIGIT_MAX_TENS);
  endfunction

  // 24h -> 12h: 00 -> 12 AM, 01..11 AM, 12 -> 12 PM, 13..23 -> H-12 PM. Minutes/seconds pass through.
  function automatic disp_t to_12h(input bcd_time_t t);
    disp_t      r;
    logic [4:0] h;
    logic [4:0] h12;
    h = {1'b0, t.h_hi} * 5'd10 + {1'b0, t.h_lo};
    if (h == 5'd0) begin
      h12 = 5'd12;
    end else if (h > 5'd12) begin
      h12 = h - 5'd12;
    end else begin
      h12 = h;
    end
    r.pm     = (h >= 5'd12);
    r.t      = t;
    r.t.h_hi = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    r.t.h_lo = (h12 >= 5'd10) ? (h12[3:0] - 4'd10) : h12[3:0];
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts 0..MAX_VAL on inc, parallel load wins over inc.
// Latency: q updates on the clock edge after inc/load; carry is combinational.
// Backpressure: none; carry is valid only in the cycle inc is applied.
module bcd_digit_counter
  import bcd_time_pkg::*;
#(
  parameter bcd_digit_t MAX_VAL = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  bcd_digit_t din,
  output bcd_digit_t q,
  output logic       carry
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  assign carry = inc && !load && (q_q == MAX_VAL);
  assign q     = q_q;

  // Next digit value: load has priority, otherwise wrap MAX_VAL -> 0 on inc.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (inc) begin
      q_d = (q_q == MAX_VAL) ? 4'd0 : q_q + 4'd1;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS time-of-day counter with own prescaler, validated load and 12h/24h display.
// Latency: tick/day_wrap same cycle; time_out/pm 1 cycle after internal time; load_err next cycle.
// Backpressure: none. Optional alarm comparator is built when ALARM_EN is defined.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_MULT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        mode_12h,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        tick,
  output logic        day_wrap,
`ifdef ALARM_EN
  input  logic [23:0] alarm_time,
  input  logic        alarm_arm,
  output logic        alarm_hit,
`endif
  output logic        load_err
);

  localparam int unsigned PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  // Multi-second steps bypass the seconds increment chain and load a binary-computed value.
  localparam bit FAST = (TICK_MULT != 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_out_q;
  logic          pm_q, load_err_q;

  bcd_time_t  load_t, cur;
  bcd_digit_t h_hi, h_lo, m_hi, m_lo, s_hi, s_lo;
  logic       load_ok, tick_int;
  logic       s_lo_c, s_hi_c, m_lo_c, m_hi_c, h_lo_c, h_hi_c;
  logic       sec_carry, hour23, hour_wrap, fast_wrap;
  logic [6:0] sec_sum, sec_next;
  bcd_digit_t s_hi_fast, s_lo_fast;
  disp_t      disp_d;

  assign load_t   = bcd_time_t'(load_time);
  assign load_ok  = load && is_valid_time(load_t);
  // An accepted load steals the tick; reset steals everything.
  assign tick_int = !rst && (state_q == RUN) && (presc_q == PRESC_MAX) && !load_ok;
  assign cur      = {h_hi, h_lo, m_hi, m_lo, s_hi, s_lo};

  // Run/halt decision follows run_en one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT:    if (run_en) state_d = RUN;
      RUN:     if (!run_en) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Prescaler: restarts on accepted load, counts only while running.
  always_comb begin
    presc_d = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end
  end

  // Seconds advance for TICK_MULT > 1: binary add, mod 60, at most one minute carry.
  assign sec_sum   = 7'(s_hi) * 7'd10 + 7'(s_lo) + 7'(TICK_MULT);
  assign fast_wrap = (sec_sum >= 7'd60);
  assign sec_next  = fast_wrap ? (sec_sum - 7'd60) : sec_sum;
  assign s_hi_fast = 4'(sec_next / 7'd10);
  assign s_lo_fast = 4'(sec_next % 7'd10);

  assign sec_carry = FAST ? (tick_int && fast_wrap) : s_hi_c;
  assign hour23    = (h_hi == DIGIT_MAX_H_HI) && (h_lo == DIGIT_MAX_H_LO_20);
  assign hour_wrap = m_hi_c && hour23;

  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_LO)) u_s_lo (
    .clk(clk), .rst(rst), .inc(tick_int && !FAST), .load(load_ok || (tick_int && FAST)),
    .din(load_ok ? load_t.s_lo : s_lo_fast), .q(s_lo), .carry(s_lo_c));

  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_TENS)) u_s_hi (
    .clk(clk), .rst(rst), .inc(s_lo_c), .load(load_ok || (tick_int && FAST)),
    .din(load_ok ? load_t.s_hi : s_hi_fast), .q(s_hi), .carry(s_hi_c));

  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_LO)) u_m_lo (
    .clk(clk), .rst(rst), .inc(sec_carry), .load(load_ok),
    .din(load_t.m_lo), .q(m_lo), .carry(m_lo_c));

  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_TENS)) u_m_hi (
    .clk(clk), .rst(rst), .inc(m_lo_c), .load(load_ok),
    .din(load_t.m_hi), .q(m_hi), .carry(m_hi_c));

  // 23 -> 00: units digit is forced to 0 while the tens digit wraps 2 -> 0 via its own carry.
  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_LO)) u_h_lo (
    .clk(clk), .rst(rst), .inc(m_hi_c && !hour23), .load(load_ok || hour_wrap),
    .din(load_ok ? load_t.h_lo : 4'd0), .q(h_lo), .carry(h_lo_c));

  bcd_digit_counter #(.MAX_VAL(DIGIT_MAX_H_HI)) u_h_hi (
    .clk(clk), .rst(rst), .inc(h_lo_c || hour_wrap), .load(load_ok),
    .din(load_t.h_hi), .q(h_hi), .carry(h_hi_c));

  // Display conversion from the current internal time.
  always_comb begin
    disp_d.pm = 1'b0;
    disp_d.t  = cur;
    if (mode_12h) begin
      disp_d = to_12h(cur);
    end
  end

  // State, prescaler, display and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HALT;
      presc_q    <= '0;
      time_out_q <= mode_12h ? TIME_12H_MIDNIGHT : 24'h0;
      pm_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      time_out_q <= disp_d.t;
      pm_q       <= disp_d.pm;
      load_err_q <= load && !is_valid_time(load_t);
    end
  end

  assign time_out = time_out_q;
  assign pm       = pm_q;
  assign tick     = tick_int;
  assign day_wrap = h_hi_c;
  assign load_err = load_err_q;

`ifdef ALARM_EN
  logic alarm_eq, alarm_eq_q, alarm_hit_q;
  assign alarm_eq = (cur == bcd_time_t'(alarm_time));

  // Pulse once when time first matches the alarm; stay quiet while it keeps matching.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_eq_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_eq_q  <= alarm_eq;
      alarm_hit_q <= alarm_arm && alarm_eq && !alarm_eq_q;
    end
  end

  assign alarm_hit = alarm_hit_q;
`endif

endmodule
